// File: rtl/sample_frame_sequencer.sv
// sample_frame_sequencer
//   Paces ADC capture with an internal sample strobe. Each capture shifts a
//   new sample into a 16-deep, 18-bit sliding window. A frame is snapshotted
//   once the window first fills, and then every HOP captures. Each frame is
//   offered to the spectrum engine over a valid/ready handshake.
//
// Parameters
//   SAMPLE_DIV  clk_25 cycles per sample tick (2 .. 2^19-1)
//   HOP         new captures between successive frames (1 .. 16)
//   DEPTH       window depth, fixed at 16 (rd_addr is 4 bits wide)
//
// Ports
//   clk_25       system clock, the only clock
//   rst_n        asynchronous active-low reset
//   enable       run sampling and scheduling while high
//   adc_sample   12-bit unsigned ADC result, captured on tick edges
//   sample_tick  one-cycle strobe; the capture happens on the edge that ends it
//   frame_valid  snapshot available to the consumer
//   frame_ready  consumer accepts the snapshot
//   rd_addr      snapshot read index, 0 = newest sample
//   rd_data      snapshot word, registered (1-cycle read latency)
//   frame_seq    frames issued, wraps modulo 256
//   overrun_cnt  frames dropped while the consumer was busy, saturates at 255
module sample_frame_sequencer #(
  parameter int SAMPLE_DIV = 10000,
  parameter int HOP        = 8,
  parameter int DEPTH      = 16
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] adc_sample,
  output logic        sample_tick,
  output logic        frame_valid,
  input  logic        frame_ready,
  input  logic [3:0]  rd_addr,
  output logic [17:0] rd_data,
  output logic [7:0]  frame_seq,
  output logic [7:0]  overrun_cnt
);

  localparam int SW = 18;
  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] DIV_MAX  = CW'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] HOP_MAX  = AW'(HOP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                   state;
  logic [CW-1:0]            tick_cnt;
  logic [AW-1:0]            fill_cnt;
  logic [AW-1:0]            hop_cnt;
  logic [DEPTH-1:0][SW-1:0] live;
  logic [DEPTH-1:0][SW-1:0] snap;
  logic [DEPTH-1:0][SW-1:0] win_nxt;
  logic                     frame_evt;
  logic                     accept;
  logic                     snap_load;

  // ---------------------------------------------------------------------------
  // Sample strobe. The counter idles at 0 while disabled, so the first tick
  // after enable rises lands SAMPLE_DIV cycles later.
  // ---------------------------------------------------------------------------
  assign sample_tick = enable && (tick_cnt == DIV_MAX);

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)                      tick_cnt <= '0;
    else if (!enable || sample_tick) tick_cnt <= '0;
    else                             tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Post-shift window. This is the next value of the live window on a tick
  // edge. A snapshot taken on the same edge reuses it, so the snapshot already
  // holds the sample being captured.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_win
    if (i == 0) begin : g_head
      assign win_nxt[i] = {adc_sample, 6'b0};
    end else begin : g_tail
      assign win_nxt[i] = live[i-1];
    end
  end

  // The live window and the snapshot survive IDLE; only reset clears them.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)           live <= '0;
    else if (sample_tick) live <= win_nxt;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)         snap <= '0;
    else if (snap_load) snap <= win_nxt;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= snap[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Frame scheduling
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_evt = 1'b0;
    if (sample_tick) begin
      case (state)
        FILL:    frame_evt = (fill_cnt == FILL_MAX);
        RUN:     frame_evt = (hop_cnt == HOP_MAX);
        default: frame_evt = 1'b0;
      endcase
    end
  end

  assign accept = frame_valid && frame_ready;
  // A frame event may load when the slot is empty, or when the current frame
  // is being accepted on the same edge (back-to-back frames, no overrun).
  assign snap_load = frame_evt && (!frame_valid || frame_ready);

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      hop_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_seq   <= '0;
      overrun_cnt <= '0;
    end else if (!enable) begin
      // A pending frame is abandoned. frame_seq and overrun_cnt persist.
      state       <= IDLE;
      fill_cnt    <= '0;
      hop_cnt     <= '0;
      frame_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FILL;
        FILL: begin
          if (sample_tick) begin
            if (fill_cnt == FILL_MAX) begin
              state   <= RUN;
              hop_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // The hop count restarts on every frame event, including dropped ones.
          if (sample_tick) hop_cnt <= (hop_cnt == HOP_MAX) ? '0 : hop_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (snap_load) begin
        frame_valid <= 1'b1;
        frame_seq   <= frame_seq + 1'b1;
      end else if (frame_evt) begin
        // The consumer still holds the previous frame. Drop the new one.
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
      end else if (accept) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_sequencer.sv
// Bench for sample_frame_sequencer. It uses SAMPLE_DIV=4, with HOP=8 on the
// main instance and HOP=1 on a second instance. The main instance is compared
// every cycle against a queue-based model of the frame rules. Directed
// sequences and a read-back table cover the fill, hop, overrun, simultaneous,
// abort and reset corners.
module tb_sample_frame_sequencer;
  localparam int DIV = 4;
  localparam int HOP = 8;

  typedef struct {
    logic [3:0]  addr;
    logic [17:0] exp;
  } rd_vec_t;

  logic        clk_25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_ready = 1'b0;
  logic [11:0] adc_sample = '0;
  logic [3:0]  rd_addr = '0;
  logic        sample_tick, frame_valid;
  logic [17:0] rd_data;
  logic [7:0]  frame_seq, overrun_cnt;

  logic        enable1 = 1'b0;
  logic        tick1, valid1;
  logic [17:0] rd1;
  logic [7:0]  seq1, ovr1;

  int checks = 0;
  int errors = 0;
  int caps_tb = 0;
  int tick_seen = 0;
  bit auto_adc = 1'b0;

  // model state
  int          en_cycles;
  int          caps;
  logic [17:0] hist[$];
  logic [17:0] m_snap[16];
  logic        m_valid;
  logic [7:0]  m_seq, m_ovr;
  logic [17:0] m_rd;

  always #5 clk_25 = ~clk_25;

  sample_frame_sequencer #(.SAMPLE_DIV(DIV), .HOP(HOP)) dut (
    .clk_25(clk_25), .rst_n(rst_n), .enable(enable), .adc_sample(adc_sample),
    .sample_tick(sample_tick), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_seq(frame_seq), .overrun_cnt(overrun_cnt)
  );

  sample_frame_sequencer #(.SAMPLE_DIV(DIV), .HOP(1)) dut1 (
    .clk_25(clk_25), .rst_n(rst_n), .enable(enable1), .adc_sample(adc_sample),
    .sample_tick(tick1), .frame_valid(valid1), .frame_ready(1'b0),
    .rd_addr(rd_addr), .rd_data(rd1), .frame_seq(seq1), .overrun_cnt(ovr1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    en_cycles = 0;
    caps = 0;
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(18'd0);
    for (int i = 0; i < 16; i++) m_snap[i] = 18'd0;
    m_valid = 1'b0;
    m_seq = 8'd0;
    m_ovr = 8'd0;
    m_rd = 18'd0;
  endtask

  task automatic model_step();
    logic [17:0] rd_next;
    bit m_tick, evt, acc;
    rd_next = m_snap[rd_addr];
    if (!enable) begin
      en_cycles = 0;
      caps = 0;
      m_valid = 1'b0;
    end else begin
      m_tick = (en_cycles % DIV) == DIV - 1;
      en_cycles++;
      acc = m_valid && frame_ready;
      evt = 1'b0;
      if (m_tick) begin
        hist.push_front({adc_sample, 6'b0});
        if (hist.size() > 16) void'(hist.pop_back());
        caps++;
        // frames after 16 captures, then every HOP captures
        evt = (caps >= 16) && (((caps - 16) % HOP) == 0);
      end
      if (evt && (!m_valid || frame_ready)) begin
        for (int i = 0; i < 16; i++) m_snap[i] = hist[i];
        m_valid = 1'b1;
        m_seq = m_seq + 8'd1;
      end else if (evt) begin
        if (m_ovr < 8'd255) m_ovr = m_ovr + 8'd1;
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end
    m_rd = rd_next;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_25 or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // continuous comparison against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk_25);
      chk("cont_tick", sample_tick, enable && ((en_cycles % DIV) == DIV - 1));
      chk("cont_valid", frame_valid, m_valid);
      chk("cont_seq", frame_seq, m_seq);
      chk("cont_ovr", overrun_cnt, m_ovr);
      chk("cont_rd", rd_data, m_rd);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One clock cycle. Inputs change 2 time units after the rising edge.
  task automatic cycle();
    bit t;
    @(negedge clk_25);
    t = sample_tick;
    @(posedge clk_25);
    #2;
    if (t) begin
      caps_tb++;
      tick_seen++;
      if (auto_adc) adc_sample = adc_sample + 12'd1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rd_vec_t vec[6];
    int n;
    int t1;
    vec[0] = '{addr: 4'd0,  exp: 18'd1024};
    vec[1] = '{addr: 4'd15, exp: 18'd64};
    vec[2] = '{addr: 4'd1,  exp: 18'd960};
    vec[3] = '{addr: 4'd7,  exp: 18'd576};
    vec[4] = '{addr: 4'd8,  exp: 18'd512};
    vec[5] = '{addr: 4'd14, exp: 18'd128};

    // reset, then idle with enable low
    @(posedge clk_25); #2;
    repeat (3) cycle();
    rst_n = 1'b1;
    tick_seen = 0;
    repeat (50) cycle();
    chk("idle_ticks", tick_seen, 0);
    chk("idle_valid", frame_valid, 0);
    chk("idle_seq", frame_seq, 0);
    chk("idle_ovr", overrun_cnt, 0);
    chk("idle_rd", rd_data, 0);

    // fill: adc = 1,2,3,... per capture
    caps_tb = 0; adc_sample = 12'd1; auto_adc = 1'b1; enable = 1'b1; n = 0;
    while (!frame_valid && n < 200) begin cycle(); n++; end
    chk("fill_latency", n, 64);
    chk("fill_caps", caps_tb, 16);
    chk("fill_seq", frame_seq, 1);
    for (int k = 0; k < 6; k++) begin
      rd_addr = vec[k].addr;
      cycle();
      chk($sformatf("fill_rd[%0d]", vec[k].addr), rd_data, vec[k].exp);
    end

    // overrun: ready held low until 40 captures after the first frame
    n = 0;
    while (caps_tb < 56 && n < 400) begin cycle(); n++; end
    chk("ovr_caps", caps_tb, 56);
    chk("ovr_cnt", overrun_cnt, 5);
    chk("ovr_seq", frame_seq, 1);
    chk("ovr_valid", frame_valid, 1);
    rd_addr = 4'd0;
    cycle();
    chk("ovr_snap0", rd_data, 1024);
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    chk("ovr_release", frame_valid, 0);

    // hop/overlap from a fresh reset, consumer always ready
    enable = 1'b0;
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    caps_tb = 0; adc_sample = 12'd1; frame_ready = 1'b1; rd_addr = 4'd0; enable = 1'b1;
    n = 0;
    while (frame_seq != 8'd2 && n < 400) begin cycle(); n++; end
    chk("hop_caps2", caps_tb, 24);
    cycle();
    chk("hop_snap2", rd_data, 24 * 64);
    n = 0;
    while (frame_seq != 8'd3 && n < 400) begin cycle(); n++; end
    chk("hop_caps3", caps_tb, 32);
    chk("hop_ovr", overrun_cnt, 0);
    cycle();
    chk("hop_valid_drop", frame_valid, 0);
    chk("hop_snap3", rd_data, 32 * 64);

    // simultaneous accept and frame event
    frame_ready = 1'b0;
    n = 0;
    while (caps_tb < 40 && n < 400) begin cycle(); n++; end
    chk("sim_valid40", frame_valid, 1);
    chk("sim_seq40", frame_seq, 4);
    n = 0;
    while (caps_tb < 47 && n < 400) begin cycle(); n++; end
    n = 0;
    while (!sample_tick && n < 10) begin cycle(); n++; end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    chk("sim_caps", caps_tb, 48);
    chk("sim_valid", frame_valid, 1);
    chk("sim_seq", frame_seq, 5);
    chk("sim_ovr", overrun_cnt, 0);
    cycle();
    chk("sim_snap", rd_data, 48 * 64);

    // abort mid-fill, then re-enable
    enable = 1'b0;
    repeat (3) cycle();
    chk("abort_idle_valid", frame_valid, 0);
    caps_tb = 0; enable = 1'b1; n = 0;
    while (caps_tb < 10 && n < 200) begin cycle(); n++; end
    enable = 1'b0;
    repeat (5) cycle();
    chk("abort_no_frame", frame_valid, 0);
    caps_tb = 0; enable = 1'b1; n = 0;
    while (!frame_valid && n < 300) begin cycle(); n++; end
    chk("abort_caps", caps_tb, 16);
    chk("abort_seq", frame_seq, 6);

    // asynchronous reset while a frame is pending
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", frame_valid, 0);
    chk("areset_seq", frame_seq, 0);
    chk("areset_ovr", overrun_cnt, 0);
    chk("areset_rd", rd_data, 0);
    chk("areset_tick", sample_tick, 0);
    enable = 1'b0;
    @(posedge clk_25); #2;
    rst_n = 1'b1;

    // randomized traffic against the model
    auto_adc = 1'b0;
    enable = 1'b1;
    repeat (3000) begin
      adc_sample = 12'($urandom);
      frame_ready = ($urandom_range(0, 3) == 0);
      rd_addr = 4'($urandom);
      if ($urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      cycle();
    end

    // HOP=1 instance: overrun saturation
    enable = 1'b0; frame_ready = 1'b0;
    adc_sample = 12'h0AB; rd_addr = 4'd15; enable1 = 1'b1;
    t1 = 0; n = 0;
    while (t1 < 116 && n < 2000) begin @(negedge clk_25); if (tick1) t1++; n++; end
    @(posedge clk_25); #2;
    chk("hop1_ovr100", ovr1, 100);
    n = 0;
    while (t1 < 316 && n < 2000) begin @(negedge clk_25); if (tick1) t1++; n++; end
    @(posedge clk_25); #2;
    chk("hop1_ovr_sat", ovr1, 255);
    chk("hop1_seq", seq1, 1);
    chk("hop1_valid", valid1, 1);
    chk("hop1_snap15", rd1, 12'h0AB * 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
